boxcar_decimator: RTL and testbench

- Downstream stage of boxcar_filter. Takes the filtered 8-bit sample stream and keeps one sample in every DECIM (decimation by DECIM).
- Buffers kept samples in a 2-entry FIFO with a valid/ready output so a slower consumer can apply backpressure.
- Flags dropped samples with a sticky overflow bit.

---
 rtl/boxcar_decimator_if.sv | 23 ++
 rtl/boxcar_decimator.sv | 89 ++++++++
 tb/tb_boxcar_decimator.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/boxcar_decimator_if.sv
// Sample stream in, decimated stream out with backpressure and status.
// The decimator connects through the slave modport and the stream source/sink through master.
interface boxcar_decimator_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  i_valid;
   logic [DATA_WIDTH-1:0] i_data;
   logic                  i_ready;
   logic                  o_valid;
   logic [DATA_WIDTH-1:0] o_data;
   logic [1:0]            o_count;
   logic                  o_overflow;

   modport master (
      output i_valid, i_data, i_ready,
      input  o_valid, o_data, o_count, o_overflow
   );

   modport slave (
      input  i_valid, i_data, i_ready,
      output o_valid, o_data, o_count, o_overflow
   );
endinterface

// File: rtl/boxcar_decimator.sv
// Keeps one valid sample in every DECIM into a 2-entry FIFO.
// A kept sample that finds the FIFO full with no pop is dropped and sets a sticky overflow flag.
module boxcar_decimator #(
   parameter int DATA_WIDTH = 8,
   parameter int DECIM      = 4
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_clear,
   boxcar_decimator_if.slave   bus
);
   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);

   logic [PW-1:0]         phase_q, phase_d;
   logic [1:0]            count_q, count_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   logic                  overflow_q, overflow_d;

   logic keep, pop, push;

   always_comb begin
      phase_d    = phase_q;
      count_d    = count_q;
      head_d     = head_q;
      tail_d     = tail_q;
      overflow_d = overflow_q;

      pop  = (count_q != 2'd0) && bus.i_ready;
      keep = bus.i_valid && (phase_q == '0);
      push = keep && ((count_q != 2'd2) || pop);

      if (i_clear) begin
         phase_d    = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (bus.i_valid) begin
            phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
         end
         if (keep && !push) begin
            overflow_d = 1'b1;
         end
         // head_q is the FIFO head and also o_data, so it is left untouched when draining to empty
         unique case ({push, pop})
            2'b10: begin
               if (count_q == 2'd0) head_d = bus.i_data;
               else                 tail_d = bus.i_data;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               if (count_q == 2'd2) head_d = tail_q;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  head_d = bus.i_data;
               end else begin
                  head_d = tail_q;
                  tail_d = bus.i_data;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         phase_q    <= '0;
         count_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         count_q    <= count_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.o_valid    = (count_q != 2'd0);
   assign bus.o_data     = head_q;
   assign bus.o_count    = count_q;
   assign bus.o_overflow = overflow_q;
endmodule

// File: tb/tb_boxcar_decimator.sv
// Drives a DECIM=4 and a DECIM=1 decimator with the same stream and checks both
// against a queue-style reference model plus directed expectations.
module tb_boxcar_decimator;
   logic clk = 1'b0;
   logic rst;
   logic clr;

   always #5 clk = ~clk;

   boxcar_decimator_if #(.DATA_WIDTH(8)) bus4 ();
   boxcar_decimator_if #(.DATA_WIDTH(8)) bus1 ();

   boxcar_decimator #(.DATA_WIDTH(8), .DECIM(4)) dut4 (
      .i_clk(clk), .i_reset(rst), .i_clear(clr), .bus(bus4)
   );
   boxcar_decimator #(.DATA_WIDTH(8), .DECIM(1)) dut1 (
      .i_clk(clk), .i_reset(rst), .i_clear(clr), .bus(bus1)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: index 0 tracks DECIM=4, index 1 tracks DECIM=1.
   int unsigned decims [2] = '{4, 1};
   int unsigned m_n    [2];
   int unsigned m_ph   [2];
   logic [7:0]  m_q    [2][2];
   logic [7:0]  m_last [2];
   bit          m_ovf  [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_n[k]    = 0;
         m_ph[k]   = 0;
         m_ovf[k]  = 1'b0;
         m_last[k] = 8'h00;
      end
   endtask

   task automatic model_step(input int k, input logic v, input logic [7:0] d,
                             input logic r, input logic c);
      if (c) begin
         m_n[k]   = 0;
         m_ph[k]  = 0;
         m_ovf[k] = 1'b0;
      end else begin
         if (m_n[k] > 0 && r) begin
            m_q[k][0] = m_q[k][1];
            m_n[k]--;
         end
         if (v) begin
            if (m_ph[k] == 0) begin
               if (m_n[k] < 2) begin
                  m_q[k][m_n[k]] = d;
                  m_n[k]++;
               end else begin
                  m_ovf[k] = 1'b1;
               end
            end
            m_ph[k] = (m_ph[k] + 1) % decims[k];
         end
      end
      if (m_n[k] > 0) m_last[k] = m_q[k][0];
   endtask

   task automatic compare_all();
      check("d4_valid", 32'(bus4.o_valid),    32'(m_n[0] != 0));
      check("d4_count", 32'(bus4.o_count),    32'(m_n[0]));
      check("d4_data",  32'(bus4.o_data),     32'(m_last[0]));
      check("d4_ovf",   32'(bus4.o_overflow), 32'(m_ovf[0]));
      check("d1_valid", 32'(bus1.o_valid),    32'(m_n[1] != 0));
      check("d1_count", 32'(bus1.o_count),    32'(m_n[1]));
      check("d1_data",  32'(bus1.o_data),     32'(m_last[1]));
      check("d1_ovf",   32'(bus1.o_overflow), 32'(m_ovf[1]));
   endtask

   task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic c);
      bus4.i_valid = v; bus4.i_data = d; bus4.i_ready = r;
      bus1.i_valid = v; bus1.i_data = d; bus1.i_ready = r;
      clr = c;
      @(posedge clk);
      model_step(0, v, d, r, c);
      model_step(1, v, d, r, c);
      #1;
      compare_all();
   endtask

   initial begin
      logic       v, r, c;
      logic [7:0] d;

      rst = 1'b1;
      clr = 1'b0;
      bus4.i_valid = 1'b0; bus4.i_data = '0; bus4.i_ready = 1'b0;
      bus1.i_valid = 1'b0; bus1.i_data = '0; bus1.i_ready = 1'b0;
      model_reset();
      #1;
      compare_all();
      @(negedge clk);
      rst = 1'b0;

      // Decimation by 4 on a continuous stream
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 8'(i), 1'b1, 1'b0);
         check("dec_valid", 32'(bus4.o_valid), 32'((i % 4) == 0));
         if ((i % 4) == 0) check("dec_data", 32'(bus4.o_data), 32'(i));
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);

      // Gapped input: phase counts valid cycles only
      cyc(1'b0, 8'h00, 1'b1, 1'b1);
      for (int i = 0; i < 16; i++) begin
         cyc(((i % 2) == 0), 8'(10 + i / 2), 1'b1, 1'b0);
         if ((i % 8) == 0) check("gap_data", 32'(bus4.o_data), 32'(10 + i / 2));
      end

      // Backpressure and overflow on the pass-through instance
      cyc(1'b0, 8'h00, 1'b1, 1'b1);
      cyc(1'b1, 8'd5, 1'b0, 1'b0);
      cyc(1'b1, 8'd6, 1'b0, 1'b0);
      cyc(1'b1, 8'd7, 1'b0, 1'b0);
      check("bp_count", 32'(bus1.o_count),    32'd2);
      check("bp_data",  32'(bus1.o_data),     32'd5);
      check("bp_ovf",   32'(bus1.o_overflow), 32'd1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("bp_drain", 32'(bus1.o_data), 32'd6);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("bp_empty", 32'(bus1.o_valid), 32'd0);

      // Full FIFO with simultaneous push and pop
      cyc(1'b0, 8'h00, 1'b1, 1'b1);
      cyc(1'b1, 8'd1, 1'b0, 1'b0);
      cyc(1'b1, 8'd2, 1'b0, 1'b0);
      cyc(1'b1, 8'd3, 1'b1, 1'b0);
      check("full_count", 32'(bus1.o_count),    32'd2);
      check("full_data",  32'(bus1.o_data),     32'd2);
      check("full_ovf",   32'(bus1.o_overflow), 32'd0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("full_last", 32'(bus1.o_data), 32'd3);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);

      // Clear wins over input and pop
      cyc(1'b1, 8'd5, 1'b0, 1'b0);
      cyc(1'b1, 8'd6, 1'b0, 1'b0);
      cyc(1'b1, 8'd7, 1'b0, 1'b0);
      cyc(1'b1, 8'd9, 1'b1, 1'b1);
      check("clr_count", 32'(bus1.o_count),    32'd0);
      check("clr_valid", 32'(bus1.o_valid),    32'd0);
      check("clr_ovf",   32'(bus1.o_overflow), 32'd0);
      cyc(1'b1, 8'd20, 1'b0, 1'b0);
      check("clr_keep4", 32'(bus4.o_data), 32'd20);
      check("clr_keep1", 32'(bus1.o_data), 32'd20);

      // Asynchronous reset between clock edges
      cyc(1'b1, 8'd33, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", 32'(bus1.o_valid), 32'd0);
      check("arst_data",  32'(bus1.o_data),  32'd0);
      check("arst_count", 32'(bus1.o_count), 32'd0);
      check("arst_data4", 32'(bus4.o_data),  32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cyc(1'b1, 8'd44, 1'b1, 1'b0);
      check("arst_keep", 32'(bus4.o_data), 32'd44);

      // Randomized traffic with occasional clears
      for (int i = 0; i < 3000; i++) begin
         v = ($urandom_range(0, 3) != 0);
         d = 8'($urandom);
         r = ($urandom_range(0, 2) == 0);
         c = ($urandom_range(0, 63) == 0);
         cyc(v, d, r, c);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
